// File: rtl/sda_reg_bus_pkg.sv
// sda_reg_bus_pkg: shared response codes and FSM encodings for the register bus master
package sda_reg_bus_pkg;
  typedef logic [1:0] state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ = 2'd1;
  localparam state_t BRESP = 2'd2;
  localparam state_t RRESP = 2'd3;
endpackage

// File: rtl/sda_reg_bus_timeout.sv
// sda_reg_bus_timeout: saturating cycle counter flagging the last allowed request cycle
module sda_reg_bus_timeout #(
  parameter int TimeoutCycles = 255
) (
  input  logic clk,
  input  logic srst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] TopCnt = CntWidth'(TimeoutCycles);
  logic [CntWidth-1:0] cnt;
  always_ff @(posedge clk)
    if (!srst_n || clear) cnt <= '0;
    else if (enable && cnt != TopCnt) cnt <= cnt + 1'b1;
  assign expired = enable && cnt == LastCnt;
endmodule

// File: rtl/sda_reg_bus_master.sv
// sda_reg_bus_master: serialises AXI4-Lite host accesses onto the shared register bus
module sda_reg_bus_master
  import sda_reg_bus_pkg::*;
#(
  parameter int RegAddrWidth = 8,
  parameter int AxiAddrWidth = 12,
  parameter int TimeoutCycles = 255
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AxiAddrWidth-1:0] s_axi_awaddr,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [AxiAddrWidth-1:0] s_axi_araddr,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  output logic [3:0]              regWStrb,
  input  logic [31:0]             regRData
);
  state_t state;
  logic awHeld, wHeld, arHeld, lastRead, readyEn, expired, idleRdy, pickWrite, pickRead, unusedAddr;
  logic [RegAddrWidth-3:0] awAddr, arAddr;
  logic [31:0] wData;
  logic [3:0] wStrb;
  // readyEn keeps every ready low in the first cycle after reset
  assign idleRdy = readyEn && state == IDLE;
  assign s_axi_awready = idleRdy && !awHeld;
  assign s_axi_wready = idleRdy && !wHeld;
  assign s_axi_arready = idleRdy && !arHeld;
  assign s_axi_bvalid = state == BRESP;
  assign s_axi_rvalid = state == RRESP;
  assign regReq = state == REQ;
  assign pickWrite = awHeld && wHeld && (!arHeld || lastRead);
  assign pickRead = arHeld && !pickWrite;
  assign unusedAddr = ^{s_axi_awaddr, s_axi_araddr};
  sda_reg_bus_timeout #(.TimeoutCycles(TimeoutCycles)) timeout (
    .clk(clk),
    .srst_n(srst_n),
    .clear(state != REQ),
    .enable(state == REQ),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state <= IDLE;
      awHeld <= 1'b0;
      wHeld <= 1'b0;
      arHeld <= 1'b0;
      lastRead <= 1'b1;
      readyEn <= 1'b0;
      awAddr <= '0;
      arAddr <= '0;
      wData <= '0;
      wStrb <= '0;
      regWriteEn <= 1'b0;
      regAddr <= '0;
      regWData <= '0;
      regWStrb <= '0;
      s_axi_bresp <= AXI_RESP_OKAY;
      s_axi_rresp <= AXI_RESP_OKAY;
      s_axi_rdata <= '0;
    end else begin
      readyEn <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        awHeld <= 1'b1;
        awAddr <= s_axi_awaddr[RegAddrWidth-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        wHeld <= 1'b1;
        wData <= s_axi_wdata;
        wStrb <= s_axi_wstrb;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        arHeld <= 1'b1;
        arAddr <= s_axi_araddr[RegAddrWidth-1:2];
      end
      case (state)
        IDLE:
          if (pickWrite || pickRead) begin
            state <= REQ;
            regWriteEn <= pickWrite;
            lastRead <= pickRead;
            regAddr <= {pickWrite ? awAddr : arAddr, 2'b00};
            regWData <= pickWrite ? wData : '0;
            regWStrb <= pickWrite ? wStrb : '0;
            if (pickWrite) begin
              awHeld <= 1'b0;
              wHeld <= 1'b0;
            end else arHeld <= 1'b0;
          end
        REQ:
          if (regAck || expired) begin
            state <= regWriteEn ? BRESP : RRESP;
            if (regWriteEn) s_axi_bresp <= regAck ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            else begin
              s_axi_rresp <= regAck ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
              s_axi_rdata <= regAck ? regRData : '0;
            end
          end
        BRESP: if (s_axi_bready) state <= IDLE;
        default: if (s_axi_rready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sda_reg_bus_master.sv
// tb_sda_reg_bus_master: directed and randomized checks against a transaction-level model
module tb_sda_reg_bus_master;
  localparam int TO = 8;
  logic clk = 0, srst_n = 0;
  logic s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
  logic [11:0] s_axi_awaddr = 0, s_axi_araddr = 0;
  logic [31:0] s_axi_wdata = 0, s_axi_rdata;
  logic [3:0] s_axi_wstrb = 0;
  logic s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
  logic s_axi_rvalid, s_axi_rready = 0;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic regReq, regAck = 0, regWriteEn;
  logic [7:0] regAddr;
  logic [31:0] regWData, regRData = 0;
  logic [3:0] regWStrb;
  int compared = 0, mismatched = 0;
  int ackAt = -1, reqCycles = 0;
  logic [31:0] slaveData = 0;
  logic prevReq = 0, lastWe = 0;
  logic [7:0] lastAddr = 0;
  logic [31:0] lastWData = 0;
  logic [3:0] lastStrb = 0;

  always #5 clk = ~clk;

  sda_reg_bus_master #(.RegAddrWidth(8), .AxiAddrWidth(12), .TimeoutCycles(TO)) dut (
    .clk(clk), .srst_n(srst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .regReq(regReq), .regAck(regAck),
    .regWriteEn(regWriteEn), .regAddr(regAddr), .regWData(regWData), .regWStrb(regWStrb),
    .regRData(regRData)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int expCycles(input int ack);
    return (ack >= 0 && ack < TO) ? ack + 1 : TO;
  endfunction

  function automatic logic [1:0] expResp(input int ack);
    return (ack >= 0 && ack < TO) ? 2'b00 : 2'b10;
  endfunction

  // Register slave: acks in request cycle ackAt (0-based), records the request fields
  always @(negedge clk) begin
    if (!srst_n) begin
      regAck = 0;
      regRData = 0;
      prevReq = 0;
    end else begin
      if (regReq) begin
        if (!prevReq) begin
          reqCycles = 0;
          lastWe = regWriteEn;
          lastAddr = regAddr;
          lastWData = regWData;
          lastStrb = regWStrb;
        end else check("req_stable", 64'({regWriteEn, regAddr, regWData, regWStrb}),
                       64'({lastWe, lastAddr, lastWData, lastStrb}));
        regAck = (reqCycles == ackAt);
        regRData = regAck ? slaveData : 32'h0;
        reqCycles++;
      end else begin
        regAck = 0;
        regRData = 0;
      end
      prevReq = regReq;
    end
  end

  task automatic sendWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int wStart;
    logic awDone, wDone, wSent;
    wStart = $urandom_range(0, 2);
    wSent = 0;
    s_axi_awaddr = a;
    s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_awvalid = 1;
    for (int n = 0; n < 50 && (s_axi_awvalid || s_axi_wvalid || !wSent); n++) begin
      if (n == wStart) begin
        s_axi_wvalid = 1;
        wSent = 1;
      end
      awDone = s_axi_awvalid && s_axi_awready;
      wDone = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      if (awDone) s_axi_awvalid = 0;
      if (wDone) s_axi_wvalid = 0;
    end
    check("aw_w_handshake", 64'({s_axi_awvalid, s_axi_wvalid}), 64'(0));
    s_axi_awvalid = 0;
    s_axi_wvalid = 0;
  endtask

  task automatic sendRead(input logic [11:0] a);
    logic arDone;
    s_axi_araddr = a;
    s_axi_arvalid = 1;
    for (int n = 0; n < 50 && s_axi_arvalid; n++) begin
      arDone = s_axi_arready;
      @(negedge clk);
      if (arDone) s_axi_arvalid = 0;
    end
    check("ar_handshake", 64'(s_axi_arvalid), 64'(0));
    s_axi_arvalid = 0;
  endtask

  task automatic waitValid(input bit isWrite);
    for (int n = 0; n < 100 && !(isWrite ? s_axi_bvalid : s_axi_rvalid); n++) @(negedge clk);
    check(isWrite ? "bvalid_wait" : "rvalid_wait", 64'(isWrite ? s_axi_bvalid : s_axi_rvalid), 64'(1));
    check("req_low_at_resp", 64'(regReq), 64'(0));
  endtask

  task automatic finishResp(input bit isWrite, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("valid_hold", 64'(isWrite ? s_axi_bvalid : s_axi_rvalid), 64'(1));
      check("no_req_in_resp", 64'(regReq), 64'(0));
    end
    if (isWrite) s_axi_bready = 1; else s_axi_rready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    s_axi_rready = 0;
    check("valid_drop", 64'({s_axi_bvalid, s_axi_rvalid}), 64'(0));
  endtask

  task automatic doWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int ack, input int delay);
    ackAt = ack;
    slaveData = $urandom;
    sendWrite(a, d, s);
    waitValid(1);
    check("wr_en", 64'(lastWe), 64'(1));
    check("wr_addr", 64'(lastAddr), 64'({a[7:2], 2'b00}));
    check("wr_data", 64'(lastWData), 64'(d));
    check("wr_strb", 64'(lastStrb), 64'(s));
    check("wr_req_cycles", 64'(reqCycles), 64'(expCycles(ack)));
    check("wr_bresp", 64'(s_axi_bresp), 64'(expResp(ack)));
    finishResp(1, delay);
  endtask

  task automatic doRead(input logic [11:0] a, input logic [31:0] d, input int ack, input int delay);
    ackAt = ack;
    slaveData = d;
    sendRead(a);
    waitValid(0);
    check("rd_en", 64'(lastWe), 64'(0));
    check("rd_addr", 64'(lastAddr), 64'({a[7:2], 2'b00}));
    check("rd_zero_wdata", 64'({lastWData, lastStrb}), 64'(0));
    check("rd_req_cycles", 64'(reqCycles), 64'(expCycles(ack)));
    check("rd_rresp", 64'(s_axi_rresp), 64'(expResp(ack)));
    check("rd_rdata", 64'(s_axi_rdata), 64'((ack >= 0 && ack < TO) ? d : 32'h0));
    finishResp(0, delay);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                           s_axi_rvalid, s_axi_rresp, regReq, regWriteEn, regWStrb}), 64'(0));
    check("rst_data", 64'({s_axi_rdata, regWData}), 64'(0));
    check("rst_addr", 64'(regAddr), 64'(0));
    srst_n = 1;
    @(negedge clk);
    check("ready_after_rst", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));

    doWrite(12'h004, 32'h1, 4'hF, 2, 0);
    doRead(12'h000, 32'h0000_000C, 0, 0);
    doRead(12'h0F0, 32'hDEAD_BEEF, -1, 1);
    doRead(12'hA3F, 32'h1234_5678, TO - 1, 0);

    ackAt = 1;
    slaveData = 32'h5A5A_0001;
    s_axi_awaddr = 12'h010;
    s_axi_wdata = 32'hCAFE_0010;
    s_axi_wstrb = 4'h3;
    s_axi_araddr = 12'h020;
    s_axi_awvalid = 1;
    s_axi_wvalid = 1;
    s_axi_arvalid = 1;
    check("simul_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));
    @(negedge clk);
    s_axi_awvalid = 0;
    s_axi_wvalid = 0;
    s_axi_arvalid = 0;
    waitValid(1);
    check("simul_first_write", 64'({lastWe, lastAddr}), 64'({1'b1, 8'h10}));
    finishResp(1, 0);
    waitValid(0);
    check("simul_second_read", 64'({lastWe, lastAddr}), 64'({1'b0, 8'h20}));
    check("simul_rdata", 64'(s_axi_rdata), 64'(32'h5A5A_0001));
    finishResp(0, 0);

    ackAt = 0;
    sendWrite(12'h008, 32'h0BAD_F00D, 4'h5);
    waitValid(1);
    slaveData = 32'h7777_0C0C;
    s_axi_araddr = 12'h00C;
    s_axi_arvalid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bhold_bvalid", 64'(s_axi_bvalid), 64'(1));
      check("bhold_no_req", 64'(regReq), 64'(0));
      check("bhold_no_arready", 64'(s_axi_arready), 64'(0));
    end
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    check("bhold_release", 64'(s_axi_bvalid), 64'(0));
    check("bhold_arready_idle", 64'(s_axi_arready), 64'(1));
    sendRead(12'h00C);
    waitValid(0);
    check("bhold_read", 64'({lastAddr, s_axi_rdata}), 64'({8'h0C, 32'h7777_0C0C}));
    finishResp(0, 0);

    ackAt = -1;
    sendRead(12'h044);
    for (int n = 0; n < 10 && !regReq; n++) @(negedge clk);
    check("midrst_req_up", 64'(regReq), 64'(1));
    @(negedge clk);
    srst_n = 0;
    @(negedge clk);
    check("midrst_drop", 64'({regReq, s_axi_bvalid, s_axi_rvalid}), 64'(0));
    srst_n = 1;
    repeat (TO + 3) @(negedge clk);
    check("midrst_no_resp", 64'({regReq, s_axi_bvalid, s_axi_rvalid}), 64'(0));
    doRead(12'h048, 32'h0000_4848, 3, 0);

    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1)
        doWrite(12'($urandom), $urandom, 4'($urandom), $urandom_range(0, TO + 1), $urandom_range(0, 3));
      else
        doRead(12'($urandom), $urandom, $urandom_range(0, TO + 1), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
